// File: rtl/float_addsub_seq.sv
// float_addsub_seq: multi-cycle FP add/sub, RNE, flush-to-zero, start/busy/done.
// Ports: clk, rst, i_start, i_op, i_x, i_y -> o_busy, o_done, o_z, o_flags (FADD_FLAGS_EN only).
module float_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_op,
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_z
`ifdef FADD_FLAGS_EN
  ,
  output logic [3:0]   o_flags
`endif
);

  localparam int MW = MAN_W + 5;
  localparam int EW = EXP_W + 1;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN =
    {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE, UNPACK, BYPASS, ALIGN, ADD, NORM, ROUND
  } state_t;

  state_t st, st_n;

  logic [W-1:0]     xr, yr, zr, xr_n, yr_n, zr_n, z_n;
  logic             sa, sb, sa_n, sb_n, done_n;
  logic [MW-1:0]    ma, mb, ma_n, mb_n;
  logic [EW-1:0]    ex, ex_n;
  logic [EXP_W-1:0] d, d_n;

  logic             xs, ys;
  logic [EXP_W-1:0] xe, ye;
  logic [MAN_W-1:0] xf, yf;
  logic             xnan, ynan, xinf, yinf, xz, yz;
  logic [MW-1:0]    mx, my;

  assign {xs, xe, xf} = xr;
  assign {ys, ye, yf} = yr;
  assign xnan = (xe == EMAX) && (xf != '0);
  assign ynan = (ye == EMAX) && (yf != '0);
  assign xinf = (xe == EMAX) && (xf == '0);
  assign yinf = (ye == EMAX) && (yf == '0);
  assign xz   = (xe == '0);
  assign yz   = (ye == '0);
  assign mx   = {2'b01, xf, 3'b000};
  assign my   = {2'b01, yf, 3'b000};

  // Right shift with sticky collection; very large
  // distances leave only the sticky bit.
  logic [MW-1:0] sh, mask;
  always_comb begin
    mask = ~({MW{1'b1}} << d);
    sh   = '0;
    if (int'(d) >= MAN_W + 3) begin
      sh[0] = |mb;
    end else begin
      sh    = mb >> d;
      sh[0] = sh[0] | (|(mb & mask));
    end
  end

  logic [MW-1:0] sum;
  logic          rsign;
  always_comb begin
    sum   = '0;
    rsign = sa;
    if (sa == sb) begin
      sum = ma + mb;
    end else if (ma >= mb) begin
      sum = ma - mb;
    end else begin
      sum   = mb - ma;
      rsign = sb;
    end
  end

  logic             inc, ovf;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] fr;
  logic [EW-1:0]    re;
  logic [W-1:0]     rz;
  always_comb begin
    inc = ma[2] & (ma[1] | ma[0] | ma[3]);
    rm  = ma[MW-1:3] + {{(MAN_W+1){1'b0}}, inc};
    re  = rm[MAN_W+1] ? ex + 1'b1 : ex;
    fr  = rm[MAN_W+1] ? rm[MAN_W:1] : rm[MAN_W-1:0];
    ovf = re >= {1'b0, EMAX};
    rz  = ovf ? {sa, EMAX, {MAN_W{1'b0}}}
              : {sa, re[EXP_W-1:0], fr};
  end

  always_comb begin
    st_n   = st;
    xr_n   = xr;
    yr_n   = yr;
    zr_n   = zr;
    sa_n   = sa;
    sb_n   = sb;
    ma_n   = ma;
    mb_n   = mb;
    ex_n   = ex;
    d_n    = d;
    z_n    = o_z;
    done_n = 1'b0;
    unique case (st)
      IDLE: begin
        if (i_start) begin
          xr_n = i_x;
          yr_n = {i_y[W-1] ^ i_op, i_y[W-2:0]};
          st_n = UNPACK;
        end
      end
      UNPACK: begin
        st_n = BYPASS;
        if (xnan || ynan) begin
          zr_n = QNAN;
        end else if (xinf && yinf) begin
          zr_n = (xs == ys) ? xr : QNAN;
        end else if (xinf) begin
          zr_n = xr;
        end else if (yinf) begin
          zr_n = yr;
        end else if (xz && yz) begin
          zr_n = {xs & ys, {(W-1){1'b0}}};
        end else if (xz) begin
          zr_n = yr;
        end else if (yz) begin
          zr_n = xr;
        end else begin
          st_n = ALIGN;
          if (xe >= ye) begin
            ma_n = mx;
            mb_n = my;
            sa_n = xs;
            sb_n = ys;
            ex_n = {1'b0, xe};
            d_n  = xe - ye;
          end else begin
            ma_n = my;
            mb_n = mx;
            sa_n = ys;
            sb_n = xs;
            ex_n = {1'b0, ye};
            d_n  = ye - xe;
          end
        end
      end
      BYPASS: begin
        z_n    = zr;
        done_n = 1'b1;
        st_n   = IDLE;
      end
      ALIGN: begin
        mb_n = sh;
        st_n = ADD;
      end
      ADD: begin
        sa_n = rsign;
        ma_n = sum;
        if (sum == '0) begin
          z_n    = '0;
          done_n = 1'b1;
          st_n   = IDLE;
        end else if (sum[MW-1]) begin
          ma_n = {1'b0, sum[MW-1:2], sum[1] | sum[0]};
          ex_n = ex + 1'b1;
          st_n = ROUND;
        end else if (sum[MW-2]) begin
          st_n = ROUND;
        end else begin
          st_n = NORM;
        end
      end
      NORM: begin
        // Leaves as soon as the shift lands a 1 in the
        // hidden position, so each step costs one cycle.
        if (ex == EW'(1)) begin
          ma_n = '0;
          ex_n = '0;
          st_n = ROUND;
        end else begin
          ma_n = ma << 1;
          ex_n = ex - 1'b1;
          st_n = ma[MW-3] ? ROUND : NORM;
        end
      end
      ROUND: begin
        z_n    = rz;
        done_n = 1'b1;
        st_n   = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      ma     <= '0;
      mb     <= '0;
      ex     <= '0;
      d      <= '0;
      o_z    <= '0;
      o_done <= 1'b0;
    end else begin
      st     <= st_n;
      xr     <= xr_n;
      yr     <= yr_n;
      zr     <= zr_n;
      sa     <= sa_n;
      sb     <= sb_n;
      ma     <= ma_n;
      mb     <= mb_n;
      ex     <= ex_n;
      d      <= d_n;
      o_z    <= z_n;
      o_done <= done_n;
    end
  end

  assign o_busy = (st != IDLE);

`ifdef FADD_FLAGS_EN
  // fl = {invalid, underflow} gathered before the result.
  logic [1:0] fl;
  logic       inx;
  assign inx = ma[2] | ma[1] | ma[0] | ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fl      <= '0;
      o_flags <= '0;
    end else begin
      unique case (st)
        UNPACK: fl <= {xinf & yinf & (xs != ys), 1'b0};
        ADD:    if (sum == '0) o_flags <= '0;
        NORM:   if (ex == EW'(1)) fl[0] <= 1'b1;
        BYPASS: o_flags <= {fl[1], 3'b000};
        ROUND:  o_flags <= {1'b0, ovf, fl[0], inx};
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_float_addsub_seq.sv
// tb_float_addsub_seq: directed vectors, queue scoreboard.
// Checks result, latency and (with FADD_FLAGS_EN) flags.
module tb_float_addsub_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_op = 1'b0;
  logic [31:0] i_x = '0;
  logic [31:0] i_y = '0;
  logic        o_busy, o_done;
  logic [31:0] o_z;
`ifdef FADD_FLAGS_EN
  logic [3:0]  o_flags;
`endif

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] z;
    logic [3:0]  f;
    int          lat;
    int          acc;
    string       nm;
  } exp_t;

  exp_t q[$];

  float_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_op(i_op),
    .i_x(i_x),
    .i_y(i_y),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_z(o_z)
`ifdef FADD_FLAGS_EN
    ,
    .o_flags(o_flags)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  task automatic wait_idle(input string nm);
    int w = 0;
    while (o_busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (o_busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_idle_timeout: busy still high", nm);
    end
  endtask

  task automatic issue(input logic [31:0] x,
                       input logic [31:0] y,
                       input logic        op,
                       input logic [31:0] z,
                       input logic [3:0]  f,
                       input int          lat,
                       input string       nm);
    exp_t e;
    @(negedge clk);
    wait_idle(nm);
    i_start = 1'b1;
    i_x = x;
    i_y = y;
    i_op = op;
    e.z = z;
    e.f = f;
    e.lat = lat;
    e.acc = cyc + 1;
    e.nm = nm;
    q.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    while (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s_missing_done: got none, expected %0h", e.nm, e.z);
    end
  endtask

  // Monitor: pops one expectation per o_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_done) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got z=%0h, expected no result", o_z);
        end else begin
          e = q.pop_front();
          chk({e.nm, "_z"}, o_z, e.z);
          chk({e.nm, "_lat"}, 32'(cyc - e.acc), 32'(e.lat));
`ifdef FADD_FLAGS_EN
          chk({e.nm, "_flags"}, 32'(o_flags), 32'(e.f));
`endif
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_z", o_z, 32'd0);
`ifdef FADD_FLAGS_EN
    chk("rst_flags", 32'(o_flags), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(o_busy), 32'd0);

    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 4, "add_1_2");
    issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 3, "sub_cancel");
    issue(32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000, 28, "sub_ulp");
    issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 4, "tie_even");
    issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 4, "tie_up");
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 4, "overflow");
    issue(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2, "inf_m_inf");
    issue(32'h00400000, 32'hBF800000, 1'b0, 32'hBF800000, 4'b0000, 2, "subn_ftz");
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 2, "neg_zeros");
    issue(32'h40400000, 32'h40000000, 1'b1, 32'h3F800000, 4'b0000, 5, "sub_3_2");
    issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 5, "sub_1_2");
    issue(32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 2, "nan_in");
    issue(32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 2, "inf_p_1");
    issue(32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 2, "zero_m_1");
    issue(32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 4'b0010, 5, "underflow");
    issue(32'h3F800000, 32'h0C800000, 1'b0, 32'h3F800000, 4'b0001, 4, "far_shift");
    drain();

    // Start requests while busy must be ignored.
    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 4, "busy_ign");
    i_start = 1'b1;
    i_x = 32'h12345678;
    i_y = 32'h40000000;
    repeat (2) @(negedge clk);
    i_start = 1'b0;
    drain();

    // Reset in the middle of a long normalisation.
    @(negedge clk);
    wait_idle("rst_mid");
    i_start = 1'b1;
    i_x = 32'h3F800000;
    i_y = 32'h3F7FFFFF;
    i_op = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy_before", 32'(o_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_z", o_z, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("post_rst_busy", 32'(o_busy), 32'd0);
    chk("post_rst_z", o_z, 32'd0);

    issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 4, "after_rst");
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
